mod_vector_pipe: RTL and testbench

Sequential, parametrised successor to the combinational vector modular reducer in the ciphertext datapath. It accepts one N-slot vector of signed WW-bit products over a valid/ready handshake. It reduces LANES slots per cycle through a PIPE-stage Barrett pipeline and returns a vec_t of canonical residues in [0, m). The modulus m is selectable per vector between the ciphertext modulus Q and the plaintext modulus T, so the same block serves both tensor-product and decode paths.

---
 rtl/mod_vector_pipe_pkg.sv | 33 +++
 rtl/mod_vector_pipe_lane.sv | 98 +++++++++
 rtl/mod_vector_pipe.sv | 137 +++++++++++++
 tb/tb_mod_vector_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_vector_pipe_pkg.sv
// Shared types, moduli and Barrett constant helpers for the vector modular reducers.
package mod_vector_pipe_pkg;

  localparam int unsigned N_SLOTS_L  = 8;
  localparam int unsigned W_BITS_L   = 16;
  localparam int unsigned WW_BITS_L  = 2 * W_BITS_L;
  localparam int unsigned Q_MOD_L    = 7710;
  localparam int unsigned T_MOD_L    = 257;

  typedef logic [W_BITS_L-1:0]        word_t;
  typedef word_t [N_SLOTS_L-1:0]      vec_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } vp_state_e;

  // k = ceil(log2 m); the reduction window spans 2k + (ww - 2k) = ww bits.
  function automatic int unsigned barrett_k(input int unsigned m);
    return $clog2(m);
  endfunction

  function automatic logic [63:0] barrett_mu(input int unsigned m, input int unsigned ww);
    int unsigned k;
    logic [63:0] num;
    k   = barrett_k(m);
    num = 64'd1 << (2 * k + (ww - 2 * k));
    return num / 64'(m);
  endfunction

endpackage

// File: rtl/mod_vector_pipe_lane.sv
// One signed Barrett reduction lane: stage 1 registers |x|, later stages carry the residue.
module mod_reduce_lane
  import mod_vector_pipe_pkg::*;
#(
  parameter int unsigned WW   = WW_BITS_L,
  parameter int unsigned W    = W_BITS_L,
  parameter int unsigned PIPE = 2,
  parameter int unsigned Q    = Q_MOD_L,
  parameter int unsigned T    = T_MOD_L
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [WW-1:0] x_i,
  input  logic          sel_i,
  output logic          valid_o,
  output logic [W-1:0]  res_o
);

  localparam logic [WW-1:0] MU_Q = WW'(barrett_mu(Q, WW));
  localparam logic [WW-1:0] MU_T = WW'(barrett_mu(T, WW));

  logic          v1_q;
  logic [WW-1:0] a1_q;
  logic          neg1_q;
  logic          sel1_q;
  logic [WW-1:0] abs_c;

  logic [WW-1:0]   m_c;
  logic [WW-1:0]   mu_c;
  logic [2*WW-1:0] prod_c;
  logic [WW-1:0]   quo_c;
  logic [WW-1:0]   qm_c;
  logic [WW-1:0]   r0_c;
  logic [WW-1:0]   r1_c;
  logic [WW-1:0]   r2_c;
  logic [WW-1:0]   fold_c;
  logic [W-1:0]    res_c;

  // Two's-complement magnitude; the most negative input maps to 2^(WW-1) exactly.
  assign abs_c = x_i[WW-1] ? (~x_i + WW'(1)) : x_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      neg1_q <= 1'b0;
      sel1_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        a1_q   <= abs_c;
        neg1_q <= x_i[WW-1];
        sel1_q <= sel_i;
      end
    end
  end

  // Quotient estimate undershoots by at most one, so r0 < 2m before correction.
  always_comb begin
    m_c    = sel1_q ? WW'(T) : WW'(Q);
    mu_c   = sel1_q ? MU_T : MU_Q;
    prod_c = {{WW{1'b0}}, a1_q} * {{WW{1'b0}}, mu_c};
    quo_c  = prod_c[2*WW-1:WW];
    qm_c   = quo_c * m_c;
    r0_c   = a1_q - qm_c;
    r1_c   = (r0_c >= m_c) ? (r0_c - m_c) : r0_c;
    r2_c   = (r1_c >= m_c) ? (r1_c - m_c) : r1_c;
    fold_c = (neg1_q && (r2_c != '0)) ? (m_c - r2_c) : r2_c;
    res_c  = W'(fold_c);
  end

  if (PIPE == 1) begin : g_p1
    assign valid_o = v1_q;
    assign res_o   = res_c;
  end else begin : g_pn
    logic [PIPE-2:0]        vs_q;
    logic [PIPE-2:0][W-1:0] rs_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vs_q <= '0;
        rs_q <= '0;
      end else begin
        vs_q[0] <= v1_q;
        if (v1_q) rs_q[0] <= res_c;
        for (int i = 1; i < int'(PIPE) - 1; i++) begin
          vs_q[i] <= vs_q[i-1];
          rs_q[i] <= rs_q[i-1];
        end
      end
    end

    assign valid_o = vs_q[PIPE-2];
    assign res_o   = rs_q[PIPE-2];
  end

endmodule

// File: rtl/mod_vector_pipe.sv
// Vector modular reducer: captures one N-slot vector, streams LANES slots per beat
// through Barrett lanes, and presents the assembled residues until consumed.
module mod_vector_pipe
  import mod_vector_pipe_pkg::*;
#(
  parameter int unsigned N     = N_SLOTS_L,
  parameter int unsigned W     = W_BITS_L,
  parameter int unsigned WW    = 2 * W_BITS_L,
  parameter int unsigned LANES = 2,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned Q     = Q_MOD_L,
  parameter int unsigned T     = T_MOD_L
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mod_sel,
  input  logic [N-1:0][WW-1:0] in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0][W-1:0]  out_vec,
  output logic                 busy
);

  localparam int unsigned BEATS = N / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  vp_state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] wbeat_q;
  logic          issue_c;
  logic          wr_c;
  logic          in_ready_q, out_valid_q, busy_q;

  logic [BEATS-1:0][LANES-1:0][WW-1:0] cap_q;
  logic                                cap_sel_q;
  logic [BEATS-1:0][LANES-1:0][W-1:0]  res_q;

  logic [LANES-1:0]        lane_vld;
  logic [LANES-1:0][W-1:0] lane_res;

  // Lanes run in lockstep, so any lane's valid marks a completed beat.
  assign wr_c = &lane_vld;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    issue_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          beat_d  = '0;
        end
      end
      S_RUN: begin
        issue_c = 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = S_DRAIN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_DRAIN: begin
        if (wr_c && (wbeat_q == LAST_BEAT)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d == S_RUN) || (state_d == S_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= '0;
      cap_sel_q <= 1'b0;
    end else if ((state_q == S_IDLE) && in_valid) begin
      cap_q     <= in_vec;
      cap_sel_q <= mod_sel;
    end
  end

  // Each emerging beat lands in its slots; results hold until the next vector overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      wbeat_q <= '0;
    end else if (wr_c) begin
      res_q[wbeat_q] <= lane_res;
      wbeat_q        <= (wbeat_q == LAST_BEAT) ? '0 : wbeat_q + BW'(1);
    end
  end

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    mod_reduce_lane #(
      .WW   (WW),
      .W    (W),
      .PIPE (PIPE),
      .Q    (Q),
      .T    (T)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (issue_c),
      .x_i     (cap_q[beat_q][l]),
      .sel_i   (cap_sel_q),
      .valid_o (lane_vld[l]),
      .res_o   (lane_res[l])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_vec   = res_q;

endmodule

// File: tb/tb_mod_vector_pipe.sv
// Directed bench for mod_vector_pipe: vector table plus backpressure, back-to-back and reset sequences.
module tb_mod_vector_pipe;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                mod_sel;
  logic [7:0][31:0]    in_vec;
  logic                out_valid;
  logic                out_ready;
  logic [7:0][15:0]    out_vec;
  logic                busy;

  typedef struct {
    logic             sel;
    logic [7:0][31:0] x;
    logic [7:0][15:0] e;
  } vec_rec_t;

  vec_rec_t tab [5];
  int total = 0;
  int bad   = 0;

  mod_vector_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mod_sel   (mod_sel),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_res(input string tag, input int idx);
    for (int s = 0; s < 8; s++)
      chk($sformatf("%s_slot%0d", tag, s), 32'(out_vec[s]), 32'(tab[idx].e[s]));
  endtask

  // Full transaction from IDLE: accept, latency, data, handshake.
  task automatic run_vec(input int idx, input string tag);
    int n;
    in_vec   = tab[idx].x;
    mod_sel  = tab[idx].sel;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    mod_sel  = ~tab[idx].sel;
    wait_out(n);
    chk({tag, "_latency"}, 32'(n), 32'd6);
    check_res(tag, idx);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0][15:0] snap;

    tab[0].sel = 1'b0;
    tab[0].x   = {32'd9041, 32'd7711, 32'd7710, 32'd7709, 32'd5, 32'd0, -32'sd20, -32'sd1};
    tab[0].e   = {16'd1331, 16'd1, 16'd0, 16'd7709, 16'd5, 16'd0, 16'd7690, 16'd7709};
    tab[1].sel = 1'b1;
    tab[1].x   = tab[0].x;
    tab[1].e   = {16'd46, 16'd1, 16'd0, 16'd256, 16'd5, 16'd0, 16'd237, 16'd256};
    tab[2].sel = 1'b0;
    tab[2].x   = {32'd1, -32'sd32768, 32'd32767, 32'd15420, -32'sd7711, -32'sd7710,
                  32'h7FFF_FFFF, 32'h8000_0000};
    tab[2].e   = {16'd1, 16'd5782, 16'd1927, 16'd0, 16'd7709, 16'd0, 16'd1927, 16'd5782};
    tab[3].sel = 1'b0;
    tab[3].x   = '0;
    tab[3].e   = '0;
    tab[4].sel = 1'b1;
    tab[4].x   = {-32'sd515, 32'd514, -32'sd256, 32'd256, -32'sd257, 32'd257,
                  32'h7FFF_FFFF, 32'h8000_0000};
    tab[4].e   = {16'd256, 16'd0, 16'd1, 16'd256, 16'd0, 16'd0, 16'd128, 16'd128};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mod_sel   = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_vec_zero", 32'(out_vec != '0), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(i, $sformatf("vec%0d", i));

    // Backpressure with an ignored input pulse while DONE.
    in_vec   = tab[0].x;
    mod_sel  = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("bp_latency", 32'(n), 32'd6);
    chk("bp_busy_done", 32'(busy), 32'd0);
    snap = tab[0].e;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        in_vec   = tab[4].x;
        mod_sel  = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk($sformatf("bp_ov_c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ir_c%0d", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp_vec_c%0d", c), 32'(out_vec != snap), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ov_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    repeat (8) tick();
    chk("bp_pulse_ignored_busy", 32'(busy), 32'd0);
    chk("bp_pulse_ignored_ov", 32'(out_valid), 32'd0);

    // Back-to-back: in_valid held, inputs changed after the first accept.
    in_vec    = tab[0].x;
    mod_sel   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_vec  = tab[1].x;
    mod_sel = 1'b1;
    wait_out(n);
    chk("b2b_first_latency", 32'(n), 32'd6);
    check_res("b2b_first", 0);
    tick();
    chk("b2b_ov_drop", 32'(out_valid), 32'd0);
    chk("b2b_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    wait_out(n);
    chk("b2b_second_latency", 32'(n), 32'd6);
    check_res("b2b_second", 1);
    tick();
    out_ready = 1'b0;
    chk("b2b_ready_end", 32'(in_ready), 32'd1);

    // Reset during RUN beat 2, then a clean vector.
    in_vec   = tab[1].x;
    mod_sel  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_ir", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_vec", 32'(out_vec != '0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    repeat (8) begin
      chk("post_rst_no_ov", 32'(out_valid), 32'd0);
      tick();
    end
    run_vec(2, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
